period_meter: RTL and testbench

- Measures the period of a slow external or generated signal (e.g. a divided 100 Hz tick or a note clock) in system-clock cycles.
- This is the inverse of the clock divider: the divider turns a cycle count into a frequency; this block turns a frequency back into a cycle count.
- It sits beside the dividers and tone generators and feeds pitch readback and self-check logic.

---
 rtl/synth_pkg.sv | 10 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/period_meter.sv | 85 ++++++++
 tb/tb_period_meter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the timing/measurement blocks: FSM encoding and defaults.
package synth_pkg;

    localparam int CLK_HZ          = 50000000;
    localparam int DEFAULT_COUNT_W = 24;

    localparam logic [0:0] ARM  = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous input and flags its rising edges (one-cycle pulse).
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_50_MHz,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to ones so an input already high at reset release is not seen as an edge.
    always_ff @(posedge CLK_50_MHz) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing of rising edges on sig_in in CLK_50_MHz cycles, with timeout.
module period_meter
    import synth_pkg::*;
#(
    parameter int COUNT_W        = DEFAULT_COUNT_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               CLK_50_MHz,
    input  logic               reset_n,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] period,
    output logic               period_valid,
    output logic               no_signal
);

    localparam logic [COUNT_W-1:0] TIMEOUT_CNT = COUNT_W'(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] COUNT_ONE   = COUNT_W'(1);

    logic               rise;
    logic [0:0]         state_q, state_d;
    logic [COUNT_W-1:0] counter_q, counter_d;
    logic [COUNT_W-1:0] period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               no_signal_q, no_signal_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK_50_MHz(CLK_50_MHz),
        .reset_n   (reset_n),
        .async_in  (sig_in),
        .rise      (rise)
    );

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        no_signal_d    = no_signal_q;
        if (state_q == ARM) begin
            counter_d = '0;
            if (rise) begin
                counter_d = COUNT_ONE;
                state_d   = MEAS;
            end
        end else begin
            // An edge landing on the timeout cycle still counts as a valid period.
            if (rise) begin
                period_d       = counter_q;
                period_valid_d = 1'b1;
                no_signal_d    = 1'b0;
                counter_d      = COUNT_ONE;
            end else if (counter_q == TIMEOUT_CNT) begin
                no_signal_d = 1'b1;
                counter_d   = '0;
                state_d     = ARM;
            end else begin
                counter_d = counter_q + COUNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK_50_MHz) begin
        if (!reset_n) begin
            state_q        <= ARM;
            counter_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            no_signal_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            no_signal_q    <= no_signal_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a long-timeout instance driven by a rise-time model, and a
// short-timeout instance driven from a hand-built table around the timeout boundary.
module tb_period_meter;

    localparam int  SYNC = 2;
    localparam int  LAT  = SYNC + 1;
    localparam int  TA   = 1000;
    localparam int  TB   = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sig_a = 1'b1;
    logic        sig_b = 1'b1;
    logic [23:0] per_a;
    logic        val_a, ns_a;
    logic [7:0]  per_b;
    logic        val_b, ns_b;

    int total = 0;
    int bad   = 0;
    longint cyc = 0;

    typedef struct {int d; int p; longint t;} pulse_t;
    typedef struct {int g; int p; bit ns; int per;} vec_t;

    pulse_t got_q[$];
    pulse_t exp_q[$];
    vec_t   tbl[8];

    bit     have_prev = 1'b0;
    longint prev_rise = 0;
    bit     last_meas = 1'b0;

    period_meter #(.COUNT_W(24), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TA)) u_a (
        .CLK_50_MHz(clk), .reset_n(reset_n), .sig_in(sig_a),
        .period(per_a), .period_valid(val_a), .no_signal(ns_a)
    );

    period_meter #(.COUNT_W(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TB)) u_b (
        .CLK_50_MHz(clk), .reset_n(reset_n), .sig_in(sig_b),
        .period(per_b), .period_valid(val_b), .no_signal(ns_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val_a) got_q.push_back('{d: 0, p: int'(per_a), t: cyc});
        if (val_b) got_q.push_back('{d: 1, p: int'(per_b), t: cyc});
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a rise is measured iff a previous rise exists since reset and lies within TA.
    task automatic rise_a();
        longint c;
        c = cyc;
        sig_a = 1'b1;
        last_meas = have_prev && (c - prev_rise <= TA);
        if (last_meas) exp_q.push_back('{d: 0, p: int'(c - prev_rise), t: c + LAT});
        have_prev = 1'b1;
        prev_rise = c;
    endtask

    task automatic period_a(input int g);
        int hi;
        hi = (g / 2 < 1) ? 1 : g / 2;
        rise_a();
        repeat (hi) @(negedge clk);
        sig_a = 1'b0;
        repeat (g - hi) @(negedge clk);
        if (g >= 5 && (g < TA - 10 || g > TA + 10))
            chk("ns_a_before_edge", longint'(ns_a), (g > TA + 10) ? 1 : longint'(!last_meas));
    endtask

    initial begin
        longint c;
        int g;

        // spacing to next rise, expected pulse period (0 = none), no_signal and period before next rise
        tbl[0] = '{g: 50, p: 0,  ns: 1'b1, per: 0};
        tbl[1] = '{g: 50, p: 50, ns: 1'b0, per: 50};
        tbl[2] = '{g: 51, p: 50, ns: 1'b0, per: 50};
        tbl[3] = '{g: 30, p: 0,  ns: 1'b1, per: 50};
        tbl[4] = '{g: 7,  p: 30, ns: 1'b0, per: 30};
        tbl[5] = '{g: 200, p: 7, ns: 1'b1, per: 7};
        tbl[6] = '{g: 5,  p: 0,  ns: 1'b1, per: 7};
        tbl[7] = '{g: 20, p: 5,  ns: 1'b0, per: 5};

        // Reset with inputs high, then 1000 quiet cycles.
        @(negedge clk);
        @(negedge clk);
        chk("rst_per_a", per_a, 0);
        chk("rst_val_a", val_a, 0);
        chk("rst_ns_a", ns_a, 1);
        chk("rst_per_b", per_b, 0);
        chk("rst_val_b", val_b, 0);
        chk("rst_ns_b", ns_b, 1);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("quiet_pulses", got_q.size(), 0);
        chk("quiet_ns_a", ns_a, 1);
        chk("quiet_per_a", per_a, 0);

        // Short-timeout instance: boundary spacing 50 is valid, 51 re-arms.
        sig_b = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            c = cyc;
            sig_b = 1'b1;
            if (tbl[i].p != 0) exp_q.push_back('{d: 1, p: tbl[i].p, t: c + LAT});
            repeat (2) @(negedge clk);
            sig_b = 1'b0;
            repeat (tbl[i].g - 2) @(negedge clk);
            chk($sformatf("b_ns[%0d]", i), ns_b, tbl[i].ns);
            chk($sformatf("b_per[%0d]", i), per_b, tbl[i].per);
        end

        // Square wave 20, then a slow divided-style tick of 700.
        sig_a = 1'b0;
        repeat (10) @(negedge clk);
        repeat (8) period_a(20);
        chk("sq20_per", per_a, 20);
        repeat (4) period_a(700);
        chk("tick700_per", per_a, 700);

        // Stop after period 100: timeout exactly TA cycles after the pulse.
        period_a(100);
        rise_a();
        repeat (50) @(negedge clk);
        sig_a = 1'b0;
        while (cyc < prev_rise + LAT + TA - 1) @(negedge clk);
        chk("to_ns_before", ns_a, 0);
        @(negedge clk);
        chk("to_ns_at", ns_a, 1);
        chk("to_per_held", per_a, 100);
        period_a(300);
        period_a(300);
        chk("after_to_per", per_a, 300);

        // Random spacings, avoiding the ambiguous window around the timeout.
        repeat (30) begin
            g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1100, 1300))
                                             : int'($urandom_range(2, 900));
            period_a(g);
        end

        // One-cycle reset in the middle of a period-40 measurement.
        repeat (3) period_a(40);
        rise_a();
        repeat (10) @(negedge clk);
        sig_a = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        have_prev = 1'b0;
        chk("mid_rst_per", per_a, 0);
        chk("mid_rst_val", val_a, 0);
        chk("mid_rst_ns", ns_a, 1);
        repeat (19) @(negedge clk);
        repeat (3) period_a(40);
        chk("post_rst_per", per_a, 40);
        repeat (10) @(negedge clk);

        chk("pulse_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("pulse%0d_dut", i), got_q[i].d, exp_q[i].d);
            chk($sformatf("pulse%0d_period", i), got_q[i].p, exp_q[i].p);
            chk($sformatf("pulse%0d_time", i), got_q[i].t, exp_q[i].t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
